// File: rtl/tl_pkg.sv
// Shared light codes, FSM state encoding and counter sizing helper
// for the crossing traffic-light sequencer.
package tl_pkg;

  typedef enum logic [1:0] {
    L_RED    = 2'b00,
    L_GREEN  = 2'b01,
    L_YELLOW = 2'b10,
    L_WALK   = 2'b11
  } light_t;

  typedef enum logic [2:0] {
    S_RED,
    S_GREEN,
    S_YELLOW,
    S_WALK,
    S_CLEAR,
    S_FLASH
  } state_t;

  // One spare bit above the longest interval keeps the down-counter clear of wrap.
  function automatic int ctrWidth(input int red, input int green, input int yellow,
                                  input int walk, input int clear);
    int m;
    m = red;
    if (green  > m) m = green;
    if (yellow > m) m = yellow;
    if (walk   > m) m = walk;
    if (clear  > m) m = clear;
    return $clog2(m) + 1;
  endfunction

endpackage

// File: rtl/crossing_fsm_phase_timer.sv
// Blink-edge tick detector plus a loadable phase down-counter with a
// "last tick of phase" flag.
module phase_timer #(
  parameter int             W           = 4,
  parameter logic [W-1:0]   RESET_COUNT = '0
) (
  input  logic         clk,
  input  logic         rstb,
  input  logic         blink_i,
  input  logic         load_i,
  input  logic [W-1:0] loadVal_i,
  output logic         tick_o,
  output logic [W-1:0] count_o,
  output logic         last_o
);

  logic         blink_q;
  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  // Delay register resets high so a blink already high at release is not a tick.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) blink_q <= 1'b1;
    else       blink_q <= blink_i;
  end

  assign tick_o = blink_i & ~blink_q;

  always_comb begin
    count_d = count_q;
    if (tick_o) count_d = load_i ? loadVal_i : count_q - 1'b1;
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) count_q <= RESET_COUNT;
    else       count_q <= count_d;
  end

  assign count_o = count_q;
  assign last_o  = (count_q == W'(1));

endmodule

// File: rtl/crossing_fsm.sv
// Traffic-light phase sequencer: normal cycle, pedestrian walk with early
// green cut-off, and night flashing-yellow mode.
module crossing_fsm
  import tl_pkg::*;
#(
  parameter int C_INT_RED       = 10,
  parameter int C_INT_GREEN     = 10,
  parameter int C_INT_MIN_GREEN = 4,
  parameter int C_INT_YELLOW    = 2,
  parameter int C_INT_WALK      = 5,
  parameter int C_INT_CLEAR     = 2
) (
  input  logic       rstb,
  input  logic       clk,
  input  logic       blink,
  input  logic       inMode,
  input  logic       inPedestrian,
  output logic [1:0] outLight,
  output logic       outEnable,
  output logic       outReqPending
);

  localparam int W = ctrWidth(C_INT_RED, C_INT_GREEN, C_INT_YELLOW, C_INT_WALK, C_INT_CLEAR);
  localparam logic [W-1:0] LEN_RED    = W'(C_INT_RED);
  localparam logic [W-1:0] LEN_GREEN  = W'(C_INT_GREEN);
  localparam logic [W-1:0] LEN_YELLOW = W'(C_INT_YELLOW);
  localparam logic [W-1:0] LEN_WALK   = W'(C_INT_WALK);
  localparam logic [W-1:0] LEN_CLEAR  = W'(C_INT_CLEAR);
  localparam logic [W-1:0] CUT_COUNT  = W'(C_INT_GREEN - C_INT_MIN_GREEN + 1);

  state_t       state_q, state_d;
  logic         enable_q, enable_d;
  logic         req_q, req_d;
  logic         tick, last, load;
  logic [W-1:0] count, loadVal;
  logic         inNormal, reqSeen;

  phase_timer #(.W(W), .RESET_COUNT(LEN_RED)) u_timer (
    .clk       (clk),
    .rstb      (rstb),
    .blink_i   (blink),
    .load_i    (load),
    .loadVal_i (loadVal),
    .tick_o    (tick),
    .count_o   (count),
    .last_o    (last)
  );

  // A press in the same cycle as a phase-ending tick already counts.
  assign inNormal = (state_q == S_RED) || (state_q == S_GREEN) || (state_q == S_YELLOW);
  assign reqSeen  = req_q | (inPedestrian & inNormal);

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_q  <= S_RED;
      enable_q <= 1'b1;
      req_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      enable_q <= enable_d;
      req_q    <= req_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (tick) begin
      unique case (state_q)
        S_RED: begin
          if (inMode)       state_d = S_FLASH;
          else if (last)    state_d = reqSeen ? S_WALK : S_GREEN;
        end
        S_GREEN: begin
          if (inMode || last || (reqSeen && count <= CUT_COUNT)) state_d = S_YELLOW;
        end
        S_YELLOW: if (last) state_d = inMode ? S_FLASH : S_RED;
        S_WALK:   if (last) state_d = S_CLEAR;
        S_CLEAR:  if (last) state_d = inMode ? S_FLASH : S_GREEN;
        S_FLASH:  if (!inMode) state_d = S_RED;
        default:  state_d = S_RED;
      endcase
    end

    // FLASH reloads every tick so the counter never free-runs there.
    load = (state_d != state_q) || (state_q == S_FLASH);
    unique case (state_d)
      S_RED:    loadVal = LEN_RED;
      S_GREEN:  loadVal = LEN_GREEN;
      S_YELLOW: loadVal = LEN_YELLOW;
      S_WALK:   loadVal = LEN_WALK;
      S_CLEAR:  loadVal = LEN_CLEAR;
      default:  loadVal = W'(1);
    endcase

    enable_d = enable_q;
    if (tick) enable_d = (state_q == S_FLASH && state_d == S_FLASH) ? ~enable_q : 1'b1;

    req_d = reqSeen;
    if (state_d != state_q && (state_d == S_WALK || state_d == S_FLASH)) req_d = 1'b0;
  end

  always_comb begin
    outEnable     = enable_q;
    outReqPending = req_q;
    unique case (state_q)
      S_GREEN:          outLight = L_GREEN;
      S_YELLOW, S_FLASH: outLight = L_YELLOW;
      S_WALK:           outLight = L_WALK;
      default:          outLight = L_RED;
    endcase
  end

endmodule

// File: tb/tb_crossing_fsm.sv
// Scoreboard bench for crossing_fsm: the driver queues expected outputs per
// blink tick and an independent monitor compares them one clk after the tick.
module tb_crossing_fsm;

  localparam logic [1:0] RED = 2'b00;
  localparam logic [1:0] GRN = 2'b01;
  localparam logic [1:0] YEL = 2'b10;
  localparam logic [1:0] WLK = 2'b11;

  typedef struct {
    logic [1:0] light;
    logic       en;
    logic       pend;
    string      name;
  } exp_t;

  logic       rstb, clk, blink, inMode, inPedestrian;
  logic [1:0] outLight;
  logic       outEnable, outReqPending;

  exp_t expQ[$];
  int   checks   = 0;
  int   failures = 0;

  crossing_fsm #(
    .C_INT_RED(3), .C_INT_GREEN(4), .C_INT_MIN_GREEN(2),
    .C_INT_YELLOW(2), .C_INT_WALK(2), .C_INT_CLEAR(1)
  ) dut (
    .rstb          (rstb),
    .clk           (clk),
    .blink         (blink),
    .inMode        (inMode),
    .inPedestrian  (inPedestrian),
    .outLight      (outLight),
    .outEnable     (outEnable),
    .outReqPending (outReqPending)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string name, input logic [1:0] light,
                             input logic en, input logic pend);
    checks++;
    if (outLight !== light || outEnable !== en || outReqPending !== pend) begin
      failures++;
      $display("[TB] FAIL %s: got light=%b en=%b pend=%b, expected light=%b en=%b pend=%b",
               name, outLight, outEnable, outReqPending, light, en, pend);
    end
  endtask

  // One blink pulse of one clk; ped=1 presses the button in that same clk.
  task automatic applyStimulus(input logic ped, input logic [1:0] light, input logic en,
                               input logic pend, input string name);
    exp_t e;
    @(negedge clk);
    e.light = light; e.en = en; e.pend = pend; e.name = name;
    expQ.push_back(e);
    blink        = 1'b1;
    inPedestrian = ped;
    @(negedge clk);
    blink        = 1'b0;
    inPedestrian = 1'b0;
  endtask

  task automatic tickN(input int n, input logic [1:0] light, input logic en,
                       input logic pend, input string name);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, light, en, pend, name);
  endtask

  task automatic pressButton();
    @(negedge clk);
    inPedestrian = 1'b1;
    @(negedge clk);
    inPedestrian = 1'b0;
  endtask

  // Monitor: derives ticks from the driven blink and checks the queued response.
  initial begin : monitor
    logic prevB, t;
    exp_t e;
    prevB = 1'b1;
    forever begin
      @(posedge clk);
      if (!rstb) prevB = 1'b1;
      else begin
        t     = blink & ~prevB;
        prevB = blink;
        if (t) begin
          #1;
          if (expQ.size() == 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL unexpected_tick: got light=%b, expected no tick", outLight);
          end else begin
            e = expQ.pop_front();
            checkOutput(e.name, e.light, e.en, e.pend);
          end
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    failures++;
    $display("[TB] FAIL timeout: got no completion, expected finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin : stimulus
    int waitCnt;
    rstb = 1'b0; blink = 1'b1; inMode = 1'b0; inPedestrian = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset_state", RED, 1'b1, 1'b0);
    rstb = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("no_tick_at_release", RED, 1'b1, 1'b0);
    blink = 1'b0;

    // Normal cycle, no presses
    tickN(2, RED, 1'b1, 1'b0, "t1_red");
    tickN(4, GRN, 1'b1, 1'b0, "t1_green");
    tickN(2, YEL, 1'b1, 1'b0, "t1_yellow");
    tickN(3, RED, 1'b1, 1'b0, "t1_red2");
    tickN(1, GRN, 1'b1, 1'b0, "t1_green2");

    // Press during first green tick: early cut-off then walk
    pressButton();
    checkOutput("t2_pend_set", GRN, 1'b1, 1'b1);
    tickN(1, GRN, 1'b1, 1'b1, "t2_green");
    tickN(2, YEL, 1'b1, 1'b1, "t2_yellow");
    tickN(3, RED, 1'b1, 1'b1, "t2_red");
    tickN(2, WLK, 1'b1, 1'b0, "t2_walk");
    tickN(1, RED, 1'b1, 1'b0, "t2_clear");
    tickN(1, GRN, 1'b1, 1'b0, "t2_green_after");

    // Press on the tick that ends RED
    tickN(3, GRN, 1'b1, 1'b0, "t3_green");
    tickN(2, YEL, 1'b1, 1'b0, "t3_yellow");
    tickN(3, RED, 1'b1, 1'b0, "t3_red");
    applyStimulus(1'b1, WLK, 1'b1, 1'b0, "t3_walk_same_clk");

    // Night mode raised mid-walk
    inMode = 1'b1;
    tickN(1, WLK, 1'b1, 1'b0, "t4_walk_completes");
    tickN(1, RED, 1'b1, 1'b0, "t4_clear");
    tickN(1, YEL, 1'b1, 1'b0, "t4_flash_entry");
    tickN(1, YEL, 1'b0, 1'b0, "t4_flash_en0");
    tickN(1, YEL, 1'b1, 1'b0, "t4_flash_en1");
    tickN(1, YEL, 1'b0, 1'b0, "t4_flash_en0b");
    inMode = 1'b0;
    tickN(3, RED, 1'b1, 1'b0, "t4_red_full");
    tickN(1, GRN, 1'b1, 1'b0, "t4_green");

    // Press ignored during flash
    inMode = 1'b1;
    tickN(2, YEL, 1'b1, 1'b0, "t5_yellow");
    tickN(1, YEL, 1'b1, 1'b0, "t5_flash_entry");
    pressButton();
    checkOutput("t5_pend_in_flash", YEL, 1'b1, 1'b0);
    tickN(1, YEL, 1'b0, 1'b0, "t5_flash_en0");
    inMode = 1'b0;
    tickN(3, RED, 1'b1, 1'b0, "t5_red");
    tickN(1, GRN, 1'b1, 1'b0, "t5_green_no_walk");

    // Asynchronous reset mid-yellow with a pending request
    tickN(3, GRN, 1'b1, 1'b0, "t6_green");
    tickN(1, YEL, 1'b1, 1'b0, "t6_yellow");
    pressButton();
    checkOutput("t6_pend_yellow", YEL, 1'b1, 1'b1);
    #2 rstb = 1'b0;
    #1 checkOutput("t6_async_reset", RED, 1'b1, 1'b0);
    repeat (2) @(negedge clk);
    rstb = 1'b1;
    tickN(2, RED, 1'b1, 1'b0, "t6_red_after_reset");
    tickN(1, GRN, 1'b1, 1'b0, "t6_green_after_reset");

    waitCnt = 0;
    while (expQ.size() != 0 && waitCnt < 20) begin
      @(negedge clk);
      waitCnt++;
    end
    if (expQ.size() != 0) begin
      checks++;
      failures++;
      $display("[TB] FAIL drain: got %0d pending expectations, expected 0", expQ.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/crossing_fsm.md
Name: crossing_fsm

Overview:
- Traffic-light phase sequencer for the crossing example.
- Sits between the debouncers/blinker (upstream) and the RGB light mapper (downstream).
- Consumes the blink timebase, the debounced mode switch and the debounced pedestrian button; produces a 2-bit light code and a light-enable.
- Implements the normal cycle, pedestrian walk with early green cut-off, and night flashing-yellow mode.

Parameters:
- C_INT_RED, 10, red phase length [ticks], >=1
- C_INT_GREEN, 10, nominal green length [ticks], >=1
- C_INT_MIN_GREEN, 4, minimum green when a pedestrian request is pending [ticks], 1..C_INT_GREEN
- C_INT_YELLOW, 2, yellow length [ticks], >=1
- C_INT_WALK, 5, walk length [ticks], >=1
- C_INT_CLEAR, 2, all-red clearance after walk [ticks], >=1

Ports:
- rstb  in  1  asynchronous reset, active low
- clk  in  1  system clock
- blink  in  1  blinker square wave; each rising edge is one tick
- inMode  in  1  debounced switch: 0 = normal, 1 = night
- inPedestrian  in  1  debounced pedestrian button, level
- outLight  out  2  light code: 00 RED, 01 GREEN, 10 YELLOW, 11 WALK
- outEnable  out  1  1 = light lit; toggles in night mode
- outReqPending  out  1  pedestrian request latched

Behaviour:
- Reset is asynchronous and active-low on rstb; the block has one clock, clk.
- Reset values:
  - state RED, counter = C_INT_RED
  - outLight = 00, outEnable = 1, outReqPending = 0
  - blink delay register = 1, so blink high at reset release produces no tick
- Tick = blink & ~blinkQ. All state and counter updates happen only on the clk edge where tick = 1. Registered outputs change on that same edge, i.e. one clk after blink is sampled high.
- Phase counter:
  - Loaded with the phase length on phase entry; decrements on each tick.
  - The phase ends on the tick when count == 1, so each phase lasts exactly N ticks.
  - Width is clog2 of the largest interval, plus 1.
- States and outputs:
  - RED: outLight 00, enable 1
  - GREEN: outLight 01, enable 1
  - YELLOW: outLight 10, enable 1
  - WALK: outLight 11, enable 1
  - CLEAR: outLight 00, enable 1
  - FLASH: outLight 10, enable toggling
- Transitions (evaluated on tick):
  - RED end: if inMode -> FLASH; else if request latched -> WALK and clear the request; else -> GREEN.
  - RED with inMode = 1 before its count ends -> FLASH immediately.
  - GREEN:
    - If inMode -> YELLOW.
    - Else if count == 1 -> YELLOW.
    - Else if request latched and count <= C_INT_GREEN - C_INT_MIN_GREEN + 1 -> YELLOW (early cut-off).
    - Otherwise decrement.
  - YELLOW end: -> FLASH if inMode, else -> RED.
  - WALK end: -> CLEAR. Always completes, even if inMode rises.
  - CLEAR end: -> FLASH if inMode, else -> GREEN.
  - FLASH: each tick toggles outEnable. On a tick with inMode = 0 -> RED with full count and outEnable = 1.
- Pedestrian request:
  - Latched (set-only) on any clk cycle with inPedestrian = 1 while in RED, GREEN or YELLOW.
  - Ignored in WALK, CLEAR and FLASH.
  - Cleared on entry to WALK and on entry to FLASH.
- Simultaneous events:
  - Request set and a tick that ends RED in the same cycle: the request counts (WALK taken).
  - inMode = 1 has priority over a pending request.
- Reset mid-phase returns to the reset state immediately; there is no partial-phase memory.

Decomposition:
- Package tl_pkg holds:
  - light codes: L_RED, L_GREEN, L_YELLOW, L_WALK
  - state enumeration: S_RED, S_GREEN, S_YELLOW, S_WALK, S_CLEAR, S_FLASH
  - function computing counter width from the parameters
- One sub-module: phase_timer, containing the tick edge detector plus a loadable down-counter with a "last" flag.
- The FSM and request latch stay in crossing_fsm.

Test Plan:
Bench parameters: RED = 3, GREEN = 4, MIN_GREEN = 2, YELLOW = 2, WALK = 2, CLEAR = 1.
- Reset with blink held high, then normal mode, no presses:
  - no tick at release
  - sequence RED 3, GREEN 4, YELLOW 2, RED 3 ticks repeats
  - outEnable constant 1
- Press during the first green tick:
  - outReqPending = 1
  - GREEN lasts 2 ticks, YELLOW 2, RED 3, WALK 2, CLEAR 1, then GREEN
  - outReqPending drops on WALK entry
- Press on the same clk as the tick ending RED: next state is WALK, not GREEN.
- inMode = 1 mid-WALK:
  - WALK completes, CLEAR 1 tick, then FLASH with outLight = 10
  - outEnable toggles 0, 1, 0 on successive ticks
  - inMode = 0 -> RED with full count of 3, enable 1
- Press during FLASH: outReqPending stays 0; after return to normal, RED -> GREEN with no WALK.
- rstb low asynchronously mid-YELLOW (between clk edges): outputs read RED/enable 1/pending 0 before the next clk edge.
